// File: rtl/axi_mult_pkg.sv
// Shared constants, FSM state types and the reset value of the times table
// used by the AXI-Lite multiplication-table slave.
package axi_mult_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         TABLE_DEPTH = 64;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } wr_state_t;

    // Entry index is {a, b}; the reset contents are simply a*b.
    function automatic logic [5:0] product_of(input logic [5:0] idx);
        logic [5:0] a;
        logic [5:0] b;
        a = {3'b000, idx[5:3]};
        b = {3'b000, idx[2:0]};
        return a * b;
    endfunction

endpackage

// File: rtl/mult_table.sv
// 64 x 6 times table: reset-initialised storage with one synchronous write
// port and one combinational read port (reads see the pre-write value).
module mult_table
    import axi_mult_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [5:0] waddr,
    input  logic [5:0] wdata,
    input  logic [5:0] raddr,
    output logic [5:0] rdata
);

    logic [5:0] mem [TABLE_DEPTH];

    // NOTE: the storage is deliberately reset because reset must restore every
    // entry to a*b; this forces flops rather than a RAM macro, which is fine at 64x6.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                // NOTE: non-blocking assignment keeps every flop sampling
                // pre-edge values, so a same-edge read sees the old entry.
                mem[i] <= product_of(6'(i));
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_lite_mult_slave.sv
// AXI4-Lite slave exposing a writable 8x8 times table at addr[7:2];
// independent read and write channel FSMs, one outstanding transaction each.
module axi_lite_mult_slave
    import axi_mult_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);

    rd_state_t  r_state;
    wr_state_t  w_state;

    logic [5:0] aw_idx_q;
    logic       aw_oor_q;
    logic [5:0] wdata_q;
    logic       wstrb0_q;

    logic       ar_hs, aw_hs, w_hs;
    logic       ar_oor;
    logic       commit;
    logic [5:0] c_idx;
    logic       c_oor;
    logic [5:0] c_data;
    logic       c_strb0;
    logic       tbl_we;
    logic [5:0] tbl_rdata;
    logic       unused_bits;

    // Readies decode the state directly so they drop during reset and rise
    // in the very first cycle after it.
    assign s_axi_arready = (r_state == R_IDLE) & ~rst;
    assign s_axi_awready = ((w_state == W_IDLE) | (w_state == W_HAVE_DATA)) & ~rst;
    assign s_axi_wready  = ((w_state == W_IDLE) | (w_state == W_HAVE_ADDR)) & ~rst;

    assign ar_hs  = s_axi_arvalid & s_axi_arready;
    assign aw_hs  = s_axi_awvalid & s_axi_awready;
    assign w_hs   = s_axi_wvalid & s_axi_wready;
    assign ar_oor = |s_axi_araddr[ADDR_W-1:8];

    // Commit on the edge that completes the address/data pair, taking each
    // half from its holding register or straight from the bus.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        commit  = 1'b0;
        c_idx   = s_axi_awaddr[7:2];
        c_oor   = |s_axi_awaddr[ADDR_W-1:8];
        c_data  = s_axi_wdata[5:0];
        c_strb0 = s_axi_wstrb[0];
        case (w_state)
            W_IDLE:      commit = aw_hs & w_hs;
            W_HAVE_ADDR: begin
                commit = w_hs;
                c_idx  = aw_idx_q;
                c_oor  = aw_oor_q;
            end
            W_HAVE_DATA: begin
                commit  = aw_hs;
                c_data  = wdata_q;
                c_strb0 = wstrb0_q;
            end
            default:     commit = 1'b0;
        endcase
    end

    assign tbl_we = commit & c_strb0 & ~c_oor;

    mult_table u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (tbl_we),
        .waddr (c_idx),
        .wdata (c_data),
        .raddr (s_axi_araddr[7:2]),
        .rdata (tbl_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= R_IDLE;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: if (ar_hs) begin
                    r_state      <= R_DATA;
                    s_axi_rvalid <= 1'b1;
                    s_axi_rdata  <= ar_oor ? '0 : {{(DATA_W-6){1'b0}}, tbl_rdata};
                    s_axi_rresp  <= ar_oor ? RESP_SLVERR : RESP_OKAY;
                end
                R_DATA: if (s_axi_rready) begin
                    r_state      <= R_IDLE;
                    s_axi_rvalid <= 1'b0;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state      <= W_IDLE;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            aw_idx_q     <= '0;
            aw_oor_q     <= 1'b0;
            wdata_q      <= '0;
            wstrb0_q     <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (commit) begin
                        w_state <= W_RESP;
                    end else if (aw_hs) begin
                        w_state  <= W_HAVE_ADDR;
                        aw_idx_q <= s_axi_awaddr[7:2];
                        aw_oor_q <= |s_axi_awaddr[ADDR_W-1:8];
                    end else if (w_hs) begin
                        w_state  <= W_HAVE_DATA;
                        wdata_q  <= s_axi_wdata[5:0];
                        wstrb0_q <= s_axi_wstrb[0];
                    end
                end
                W_HAVE_ADDR: if (commit) w_state <= W_RESP;
                W_HAVE_DATA: if (commit) w_state <= W_RESP;
                W_RESP: if (s_axi_bready) begin
                    w_state      <= W_IDLE;
                    s_axi_bvalid <= 1'b0;
                end
                default: w_state <= W_IDLE;
            endcase
            if (commit) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= c_oor ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Byte-offset bits, upper data bits and upper strobes carry no meaning here.
    assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0],
                           s_axi_wdata[DATA_W-1:6], s_axi_wstrb[DATA_W/8-1:1]};

endmodule

// File: tb/tb_axi_lite_mult_slave.sv
// Self-checking bench: directed protocol scenarios plus randomized traffic
// checked against an array model of the times table.
module tb_axi_lite_mult_slave;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] s_axi_awaddr;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [DATA_W-1:0] s_axi_wdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [DATA_W-1:0] s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;

    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned model [64];

    always #5 clk = ~clk;

    axi_lite_mult_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    endtask

    function automatic void model_reset();
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                model[a*8 + b] = a * b;
    endfunction

    function automatic bit in_range(input logic [31:0] addr);
        return addr < 32'h100;
    endfunction

    // Read transaction; all sampling and driving happens on the falling edge.
    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        while (!s_axi_arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ar_timeout", 32'd1, 32'd0);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        check("rvalid_latency", 32'(s_axi_rvalid), 32'd1);
        data = s_axi_rdata;
        resp = s_axi_rresp;
        s_axi_rready = 1'b1;
        @(negedge clk);
        s_axi_rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        bit aw_pend = 1'b1, w_pend = 1'b1, aw_go, w_go;
        int n = 0;
        s_axi_awaddr  = addr;
        s_axi_awvalid = 1'b1;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_wvalid  = 1'b1;
        while ((aw_pend || w_pend) && n < 50) begin
            aw_go = aw_pend && s_axi_awready;
            w_go  = w_pend && s_axi_wready;
            @(negedge clk);
            n++;
            if (aw_go) begin s_axi_awvalid = 1'b0; aw_pend = 1'b0; end
            if (w_go)  begin s_axi_wvalid  = 1'b0; w_pend  = 1'b0; end
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        n = 0;
        while (!s_axi_bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("b_timeout", 32'd1, 32'd0);
        resp = s_axi_bresp;
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check("rst_arready", 32'(s_axi_arready), 32'd0);
        check("rst_awready", 32'(s_axi_awready), 32'd0);
        check("rst_wready",  32'(s_axi_wready),  32'd0);
        check("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
        check("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
        check("rst_rdata",   s_axi_rdata,        32'd0);
        check("rst_resp",    32'({s_axi_rresp, s_axi_bresp}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'({s_axi_arready, s_axi_awready, s_axi_wready}), 32'b111);
        @(negedge clk);
    endtask

    logic [31:0] rd;
    logic [1:0]  rr, br;

    initial begin
        rst = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        pulse_reset();

        do_read(32'h74, rd, rr);
        check("rd_0x74", rd, 32'h0000_000F);
        check("rresp_0x74", 32'(rr), 32'd0);
        do_read(32'hFC, rd, rr);
        check("rd_0xFC", rd, 32'd49);
        do_read(32'h100, rd, rr);
        check("rd_oor_data", rd, 32'd0);
        check("rd_oor_resp", 32'(rr), 32'b10);

        do_write(32'h74, 32'hFFFF_FFEA, 4'h1, br);
        check("wr_0x74_bresp", 32'(br), 32'd0);
        do_read(32'h74, rd, rr);
        check("rd_after_wr", rd, 32'h2A);
        pulse_reset();
        do_read(32'h74, rd, rr);
        check("rd_after_rst", rd, 32'd15);

        // Reset mid-write: address accepted, data never sent.
        s_axi_awaddr = 32'h74; s_axi_awvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        pulse_reset();
        check("midwr_bvalid", 32'(s_axi_bvalid), 32'd0);

        // W two cycles ahead of AW, then a stalled response.
        s_axi_wdata = 32'd7; s_axi_wstrb = 4'h1; s_axi_wvalid = 1'b1;
        check("w_first_wready", 32'(s_axi_wready), 32'd1);
        @(negedge clk);
        s_axi_wvalid = 1'b0;
        check("wready_drops", 32'(s_axi_wready), 32'd0);
        check("awready_waits", 32'(s_axi_awready), 32'd1);
        @(negedge clk);
        check("no_bvalid_yet", 32'(s_axi_bvalid), 32'd0);
        s_axi_awaddr = 32'h0C; s_axi_awvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        model[3] = 7;
        check("bvalid_next_cycle", 32'(s_axi_bvalid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bvalid_hold", 32'(s_axi_bvalid), 32'd1);
            check("aw_w_ready_low", 32'({s_axi_awready, s_axi_wready}), 32'd0);
        end
        check("bresp_okay", 32'(s_axi_bresp), 32'd0);
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        check("bvalid_clears", 32'(s_axi_bvalid), 32'd0);
        do_read(32'h0C, rd, rr);
        check("rd_0x0C", rd, 32'd7);

        // Read of 0x58 with rready stalled.
        s_axi_araddr = 32'h58; s_axi_arvalid = 1'b1;
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        check("rvalid_0x58", 32'(s_axi_rvalid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("rdata_hold", s_axi_rdata, 32'd12);
            check("arready_low", 32'(s_axi_arready), 32'd0);
            @(negedge clk);
        end
        s_axi_rready = 1'b1;
        @(negedge clk);
        s_axi_rready = 1'b0;
        check("arready_back", 32'(s_axi_arready), 32'd1);
        check("rvalid_clears", 32'(s_axi_rvalid), 32'd0);

        // Same-edge AR and commit to 0x24.
        s_axi_awaddr = 32'h24; s_axi_awvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        s_axi_wdata = 32'd9; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        s_axi_araddr = 32'h24; s_axi_arvalid = 1'b1;
        @(negedge clk);
        s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        check("same_edge_rd", s_axi_rdata, 32'd1);
        check("same_edge_bvalid", 32'(s_axi_bvalid), 32'd1);
        s_axi_rready = 1'b1; s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_rready = 1'b0; s_axi_bready = 1'b0;
        model[9] = 9;
        do_read(32'h24, rd, rr);
        check("rd_after_same_edge", rd, 32'd9);

        // Randomized traffic against the model.
        for (int i = 0; i < 60; i++) begin
            logic [5:0]  idx;
            logic [31:0] addr, wd;
            logic [3:0]  strb;
            bit          oor;
            idx  = 6'($urandom_range(0, 63));
            oor  = ($urandom_range(0, 7) == 0);
            addr = {24'd0, idx, 2'($urandom_range(0, 3))};
            if (oor) addr = addr | (32'($urandom_range(1, 16'hFFFF)) << 8);
            if ($urandom_range(0, 1) == 1) begin
                wd   = $urandom;
                strb = 4'($urandom_range(0, 15));
                do_write(addr, wd, strb, br);
                if (in_range(addr) && strb[0]) model[idx] = wd % 64;
                check("rnd_bresp", 32'(br), in_range(addr) ? 32'd0 : 32'd2);
            end else begin
                do_read(addr, rd, rr);
                check("rnd_rdata", rd, in_range(addr) ? model[idx] : 32'd0);
                check("rnd_rresp", 32'(rr), in_range(addr) ? 32'd0 : 32'd2);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
